// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctrl_pkg;

    // MDU sequencer states.
    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // Default MDU latencies in cycles.
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/hazard_ctrl_mdu_sequencer.sv
// MULT/DIV sequencer: tracks one in-flight MDU operation with a down-counter
// and pulses done in the last busy cycle, when HI/LO are written.
module mdu_sequencer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter load/decrement, busy and done decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = (state_q == MDU_BUSY);
        done    = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            MDU_BUSY: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = MDU_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, taken-branch
// flushes and MDU structural stalls on HI/LO.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic       use_rs_ID,
    input  logic       use_rt_ID,
    input  logic       ctrlMemRead_ID_EX,
    input  logic [4:0] rd_ID_EX,
    input  logic       branch_taken_EX,
    input  logic       mdu_op_ID,
    input  logic       mdu_is_div_ID,
    input  logic       hilo_use_ID,
    output logic       stall_PC,
    output logic       stall_IF_ID,
    output logic       bubble_ID_EX,
    output logic       flush_IF_ID,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic       mdu_done
);

    logic lu, sh, stall, advance, start;
    logic seq_busy, seq_done;

    mdu_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (mdu_is_div_ID),
        .busy   (seq_busy),
        .done   (seq_done)
    );

    // Hazard detection; a taken branch squashes the younger ID instruction,
    // so it overrides any stall. Everything is held low during reset.
    always_comb begin
        lu = ctrlMemRead_ID_EX && (rd_ID_EX != 5'd0) &&
             ((use_rs_ID && (rs_ID == rd_ID_EX)) ||
              (use_rt_ID && (rt_ID == rd_ID_EX)));
        sh      = seq_busy && (mdu_op_ID || hilo_use_ID);
        stall   = (lu || sh) && !branch_taken_EX;
        advance = !stall && !branch_taken_EX;
        start   = !rst && advance && mdu_op_ID && !seq_busy;

        stall_PC     = !rst && stall;
        stall_IF_ID  = !rst && stall;
        bubble_ID_EX = !rst && (stall || branch_taken_EX);
        flush_IF_ID  = !rst && branch_taken_EX;
        mdu_start    = start;
        mdu_busy     = !rst && seq_busy;
        mdu_done     = !rst && seq_done;
    end

endmodule
